// File: rtl/sisc_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : sisc_ctrl_mc_if
// Description : Bundle between the SISC IR/status register and the multi-cycle
//               controller (master) and the datapath it steers (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sisc_ctrl_mc_if #(
  parameter int CC_W  = 4,
  parameter int ALU_W = 4
);
  // Instruction / status side
  logic [3:0]       opcode;
  logic [CC_W-1:0]  mm;
  logic [CC_W-1:0]  stat;
  logic             mem_ready;

  // Datapath controls
  logic             rf_we;
  logic             wb_sel;
  logic [ALU_W-1:0] alu_op;
  logic             br_sel;
  logic             pc_rst;
  logic             pc_write;
  logic             pc_sel;
  logic             ir_load;
  logic             mem_req;
  logic             dm_we;
  logic             halted;
  logic             err;

  // Controller view
  modport master (
    input  opcode, mm, stat, mem_ready,
    output rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel,
           ir_load, mem_req, dm_we, halted, err
  );

  // Datapath view
  modport slave (
    output opcode, mm, stat, mem_ready,
    input  rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel,
           ir_load, mem_req, dm_we, halted, err
  );
endinterface
`default_nettype wire

// File: rtl/sisc_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : sisc_ctrl_mc
// Description : Multi-cycle SISC control unit. Sequences
//               FETCH/DECODE/EXECUTE/MEM/WRITEBACK, resolves condition-code
//               branches in DECODE, drives LOD/STR data-memory strobes and
//               parks in a registered HALT state on HLT.
//               Optional macro SISC_CTRL_MEM_HS_EN: MEM waits on mem_ready for
//               LOD/STR with a MEM_TIMEOUT-cycle watchdog raising err.
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_ctrl_mc #(
  parameter int CC_W        = 4,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  sisc_ctrl_mc_if.master    bus
);

  localparam logic [3:0] OP_REG_OP = 4'b0001;
  localparam logic [3:0] OP_REG_IM = 4'b0010;
  localparam logic [3:0] OP_BRA    = 4'b0100;
  localparam logic [3:0] OP_BRR    = 4'b0101;
  localparam logic [3:0] OP_BNE    = 4'b0110;
  localparam logic [3:0] OP_BNR    = 4'b0111;
  localparam logic [3:0] OP_LOD    = 4'b1000;
  localparam logic [3:0] OP_STR    = 4'b1001;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [ALU_W-1:0] ALU_ZERO    = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_EXE_REG = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_MEM_IMM = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_EXE_IMM = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_ADDR    = ALU_W'(4);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Opcode classification
  logic            is_mem, is_str, is_lod, is_rel, br_taken;
  logic [CC_W-1:0] cc_hit;
  logic [ALU_W-1:0] alu_exe, alu_mem;

  assign is_lod = (bus.opcode == OP_LOD);
  assign is_str = (bus.opcode == OP_STR);
  assign is_mem = is_lod | is_str;
  assign is_rel = (bus.opcode == OP_BRR) | (bus.opcode == OP_BNR);
  assign cc_hit = bus.stat & bus.mm;

  // Branch taken on any matching CC (BRA/BRR) or on no match (BNE/BNR)
  always_comb begin
    br_taken = 1'b0;
    case (bus.opcode)
      OP_BRA, OP_BRR: br_taken = (cc_hit != '0);
      OP_BNE, OP_BNR: br_taken = (cc_hit == '0);
      default:        br_taken = 1'b0;
    endcase
  end

  // ALU operation selection for EXECUTE and for MEM/WRITEBACK
  always_comb begin
    alu_exe = ALU_ZERO;
    alu_mem = ALU_ZERO;
    case (bus.opcode)
      OP_REG_OP: begin alu_exe = ALU_EXE_REG; alu_mem = ALU_ZERO;    end
      OP_REG_IM: begin alu_exe = ALU_EXE_IMM; alu_mem = ALU_MEM_IMM; end
      OP_LOD,
      OP_STR:    begin alu_exe = ALU_ADDR;    alu_mem = ALU_ADDR;    end
      default:   begin alu_exe = ALU_ZERO;    alu_mem = ALU_ZERO;    end
    endcase
  end

`ifdef SISC_CTRL_MEM_HS_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // Wait counter and sticky timeout flag; only reset clears err
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_mem_hs;
  assign unused_mem_hs = bus.mem_ready ^ (MEM_TIMEOUT != 0);
  assign bus.err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d      = state_q;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.alu_op   = ALU_ZERO;
    bus.br_sel   = 1'b0;
    bus.pc_rst   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.mem_req  = 1'b0;
    bus.dm_we    = 1'b0;
    bus.halted   = 1'b0;
`ifdef SISC_CTRL_MEM_HS_EN
    // Counter idles at zero outside MEM so every MEM entry starts fresh
    wait_cnt_d   = '0;
    err_d        = err_q;
`endif
    case (state_q)
      ST_START: begin
        bus.pc_rst = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
        bus.pc_sel   = 1'b0;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        if (br_taken) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = 1'b1;
          bus.br_sel   = is_rel;
        end
        state_d = (bus.opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        bus.alu_op = alu_exe;
        state_d    = ST_MEM;
      end
      ST_MEM: begin
        bus.alu_op  = alu_mem;
        bus.mem_req = is_mem;
        bus.dm_we   = is_str;
        state_d     = ST_WB;
`ifdef SISC_CTRL_MEM_HS_EN
        if (is_mem && !bus.mem_ready) begin
          if (wait_cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            state_d    = ST_MEM;
          end
        end
`endif
      end
      ST_WB: begin
        bus.alu_op = alu_mem;
        bus.rf_we  = (bus.opcode == OP_REG_OP) | (bus.opcode == OP_REG_IM) | is_lod;
        bus.wb_sel = is_lod;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        bus.halted = 1'b1;
        state_d    = ST_HALT;
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

endmodule
`default_nettype wire
